// File: rtl/key_event_queue_pkg.sv
// Shared keypad constants and types for the key-event queue and its FIFO.
package key_event_queue_pkg;

  // Keypad geometry shared with the key matrix scanner and edge detector.
  localparam int KEY_COUNT = 16;
  localparam int KEY_IDX_W = 4;

  // Event queue sizing; depth must stay a power of two so pointers wrap naturally.
  localparam int QUEUE_DEPTH = 4;
  localparam int QUEUE_PTR_W = 2;

  typedef logic [KEY_COUNT-1:0] key_vec_t;
  typedef logic [KEY_IDX_W-1:0] key_idx_t;

endpackage : key_event_queue_pkg

// File: rtl/key_event_queue_sync_fifo.sv
// First-word fall-through FIFO with explicit occupancy counter, synchronous
// flush and asynchronous active-low reset. The head output holds its last
// value while the FIFO is empty.
module sync_fifo
  import key_event_queue_pkg::*;
#(
  parameter int WIDTH = KEY_IDX_W,
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int PTR_W = QUEUE_PTR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [WIDTH-1:0] last_head_q, last_head_d;
  logic             do_push;
  logic             do_pop;
  logic             not_empty;

  assign not_empty = (count_q != '0);

  // Qualify requests: a pop needs data, a push needs a free slot or a same-cycle pop.
  always_comb begin
    do_pop  = pop && not_empty;
    do_push = push && ((count_q != FullCount) || do_pop);
  end

  // Next pointers, occupancy and remembered head; clear wins over everything.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_head_d = last_head_q;
    if (not_empty) begin
      last_head_d = mem_q[rd_ptr_q];
    end
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, occupancy and last-head registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_head_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_head_q <= last_head_d;
    end
  end

  // Storage array; when full, a simultaneous pop frees the slot being written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (!clear && do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Fall-through head: live entry when non-empty, otherwise the last head seen.
  always_comb begin
    valid = not_empty;
    count = count_q;
    head  = not_empty ? mem_q[rd_ptr_q] : last_head_q;
  end

endmodule : sync_fifo

// File: rtl/key_event_queue.sv
// Key-event queue: turns one-cycle key press pulses into an ordered stream of
// key indices. Presses that cannot enter the FIFO wait in a one-bit-per-key
// pending register; a second press of a key already pending sets overflow.
module key_event_queue
  import key_event_queue_pkg::*;
#(
  parameter int WIDTH = KEY_COUNT,
  parameter int IDX_W = KEY_IDX_W,
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int PTR_W = QUEUE_PTR_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] press,
  input  logic             clear,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_key,
  input  logic             evt_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] push_mask;
  logic [WIDTH-1:0] dup_mask;
  logic [IDX_W-1:0] push_idx;
  logic             push_found;
  logic             pop;
  logic             space;
  logic             push;
  logic             fifo_valid;
  logic [IDX_W-1:0] fifo_head;
  logic [PTR_W:0]   fifo_count;

  // Lowest-index-first priority encoder over waiting and newly pressed keys.
  always_comb begin
    merged     = pending_q | press;
    push_idx   = '0;
    push_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (merged[i] && !push_found) begin
        push_idx   = IDX_W'(i);
        push_found = 1'b1;
      end
    end
  end

  // One push per cycle, allowed when a slot is free or is being freed by a pop.
  always_comb begin
    pop       = fifo_valid && evt_ready;
    space     = (fifo_count < FullCount) || pop;
    push      = push_found && space;
    push_mask = '0;
    if (push) begin
      push_mask[push_idx] = 1'b1;
    end
    dup_mask  = press & pending_q & ~push_mask;
  end

  // Pending and overflow next state; clear flushes both.
  always_comb begin
    if (clear) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else begin
      pending_d  = merged & ~push_mask;
      overflow_d = overflow_q | (|dup_mask);
    end
  end

  // Pending slots and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (push),
    .push_data (push_idx),
    .pop       (pop),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Outputs come straight from registered FIFO state and the overflow flag.
  always_comb begin
    evt_valid = fifo_valid;
    evt_key   = fifo_head;
    count     = fifo_count;
    overflow  = overflow_q;
  end

endmodule : key_event_queue

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: a fixed vector table, hand-written
// corner sequences and a randomized run, all compared against a queue model.
module tb_key_event_queue;

  logic        clk;
  logic        reset_n;
  logic [15:0] press;
  logic        clear;
  logic        evt_valid;
  logic [3:0]  evt_key;
  logic        evt_ready;
  logic [2:0]  count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mq[$];
  logic [15:0] mPend;
  bit          mOvf;
  int          mLast;
  int          expQ[$];

  typedef struct {
    logic [15:0] press;
    bit          ready;
    bit          clr;
    bit          expValid;
    int          expKey;
    int          expCount;
    bit          expOvf;
  } vec_t;

  vec_t vecs[9];

  key_event_queue dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .press     (press),
    .clear     (clear),
    .evt_valid (evt_valid),
    .evt_key   (evt_key),
    .evt_ready (evt_ready),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on total run time
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, need $finish");
    $fatal(1);
  end

  task automatic modelReset();
    mq.delete();
    mPend = '0;
    mOvf  = 1'b0;
    mLast = 0;
  endtask

  // Queue-level model of one clock edge
  task automatic modelEdge(input logic [15:0] p, input bit rdy, input bit clr);
    bit          doPop;
    bit          hasSpace;
    logic [15:0] m;
    logic [15:0] pm;
    if (mq.size() > 0) mLast = mq[0];
    if (clr) begin
      mq.delete();
      mPend = '0;
      mOvf  = 1'b0;
    end else begin
      doPop    = (mq.size() > 0) && rdy;
      hasSpace = (mq.size() < 4) || doPop;
      m        = mPend | p;
      pm       = '0;
      if (doPop) void'(mq.pop_front());
      if ((m != 0) && hasSpace) begin
        for (int k = 0; k < 16; k++) begin
          if (m[k]) begin
            mq.push_back(k);
            pm[k] = 1'b1;
            break;
          end
        end
      end
      if ((p & mPend & ~pm) != 0) mOvf = 1'b1;
      mPend = m & ~pm;
    end
  endtask

  task automatic checkOutput(input string name, input bit ev, input int ek,
                             input int ec, input bit eo);
    checks++;
    if (evt_valid !== ev || int'(evt_key) != ek || int'(count) != ec || overflow !== eo) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%0b key=%0d count=%0d ovf=%0b, need valid=%0b key=%0d count=%0d ovf=%0b",
               name, evt_valid, evt_key, count, overflow, ev, ek, ec, eo);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, mq.size() > 0, (mq.size() > 0) ? mq[0] : mLast, mq.size(), mOvf);
  endtask

  // Drive one cycle of inputs, advance one edge and compare against the model
  task automatic applyStimulus(input logic [15:0] p, input bit rdy, input bit clr, input string name);
    press     = p;
    evt_ready = rdy;
    clear     = clr;
    modelEdge(p, rdy, clr);
    @(posedge clk);
    #1;
    checkModel(name);
  endtask

  // Pop entries and compare each head with expQ, bounded by its length
  task automatic drainExpect(input string name);
    for (int i = 0; i < expQ.size(); i++) begin
      checks++;
      if (!evt_valid || int'(evt_key) != expQ[i]) begin
        errors++;
        $display("[TB] FAIL %s[%0d]: got valid=%0b key=%0d, need valid=1 key=%0d",
                 name, i, evt_valid, evt_key, expQ[i]);
      end
      applyStimulus('0, 1'b1, 1'b0, name);
    end
    checkOutput({name, "_empty"}, 1'b0, expQ[expQ.size()-1], 0, mOvf);
  endtask

  task automatic fillFour(input logic [15:0] p, input string name);
    applyStimulus(p, 1'b0, 1'b0, name);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b0, name);
    checkOutput({name, "_full"}, 1'b1, mq[0], 4, mOvf);
  endtask

  initial begin
    vecs[0] = '{16'h0020, 1'b0, 1'b0, 1'b1,  5, 1, 1'b0};
    vecs[1] = '{16'h0000, 1'b1, 1'b0, 1'b0,  5, 0, 1'b0};
    vecs[2] = '{16'h8101, 1'b0, 1'b0, 1'b1,  0, 1, 1'b0};
    vecs[3] = '{16'h0000, 1'b0, 1'b0, 1'b1,  0, 2, 1'b0};
    vecs[4] = '{16'h0000, 1'b0, 1'b0, 1'b1,  0, 3, 1'b0};
    vecs[5] = '{16'h0000, 1'b1, 1'b0, 1'b1,  8, 2, 1'b0};
    vecs[6] = '{16'h0000, 1'b1, 1'b0, 1'b1, 15, 1, 1'b0};
    vecs[7] = '{16'h0000, 1'b1, 1'b0, 1'b0, 15, 0, 1'b0};
    vecs[8] = '{16'h0000, 1'b1, 1'b0, 1'b0, 15, 0, 1'b0};

    reset_n   = 1'b0;
    press     = '0;
    clear     = 1'b0;
    evt_ready = 1'b0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 0, 0, 1'b0);
    reset_n = 1'b1;

    // Single key and simultaneous presses from the vector table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].press, vecs[i].ready, vecs[i].clr, "table_model");
      checkOutput($sformatf("table_%0d", i), vecs[i].expValid, vecs[i].expKey,
                  vecs[i].expCount, vecs[i].expOvf);
    end

    // Async reset mid-stream with three entries queued
    applyStimulus(16'h0007, 1'b0, 1'b0, "rst_fill");
    applyStimulus('0, 1'b0, 1'b0, "rst_fill");
    applyStimulus(16'h0100, 1'b0, 1'b0, "rst_fill");
    checkOutput("rst_three_queued", 1'b1, 0, 3, 1'b0);
    #2;
    reset_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_async", 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, "rst_after");
    checkOutput("rst_pending_gone", 1'b0, 0, 0, 1'b0);

    // Full queue: presses wait in pending, then enter in order as slots free
    fillFour(16'h000F, "full");
    applyStimulus(16'h0006, 1'b0, 1'b0, "full_press");
    checkOutput("full_hold", 1'b1, 0, 4, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, "full_idle");
    applyStimulus('0, 1'b1, 1'b0, "full_pop1");
    checkOutput("full_pop1_cnt", 1'b1, 1, 4, 1'b0);
    applyStimulus('0, 1'b1, 1'b0, "full_pop2");
    checkOutput("full_pop2_cnt", 1'b1, 2, 4, 1'b0);
    expQ = '{2, 3, 1, 2};
    drainExpect("full_drain");

    // Duplicate press of a pending key sets overflow and merges
    applyStimulus('0, 1'b0, 1'b1, "dup_clear");
    fillFour(16'h0017, "dup");
    applyStimulus(16'h0008, 1'b0, 1'b0, "dup_first");
    checkOutput("dup_first_ovf", 1'b1, 0, 4, 1'b0);
    applyStimulus('0, 1'b0, 1'b0, "dup_idle");
    applyStimulus(16'h0008, 1'b0, 1'b0, "dup_second");
    checkOutput("dup_ovf_set", 1'b1, 0, 4, 1'b1);
    expQ = '{0, 1, 2, 4, 3};
    drainExpect("dup_drain");
    applyStimulus('0, 1'b0, 1'b1, "dup_clr");
    checkOutput("dup_cleared", 1'b0, 3, 0, 1'b0);

    // Push and pop together at full occupancy
    fillFour(16'h000F, "pp");
    applyStimulus(16'h0400, 1'b1, 1'b0, "pp_both");
    checkOutput("pp_count_held", 1'b1, 1, 4, 1'b0);
    expQ = '{1, 2, 3, 10};
    drainExpect("pp_drain");

    // Clear has priority over simultaneous press and pop
    applyStimulus(16'h0003, 1'b0, 1'b0, "clr_pre");
    applyStimulus(16'h0010, 1'b1, 1'b1, "clr_prio");
    checkOutput("clr_prio_out", 1'b0, 0, 0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] p;
      p = '0;
      if ($urandom_range(0, 2) == 0) p = 16'($urandom) & 16'($urandom) & 16'($urandom);
      applyStimulus(p, ($urandom_range(0, 2) != 0), ($urandom_range(0, 99) == 0), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_event_queue
